alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
// - Upstream feeder for the 2-bit-control ALU: accepts an 11-bit instruction, reads two operands from an
//   internal 8x5 register file, and drives ALU a/b/control.
// - Captures the ALU's 10-bit result and zFlag, then writes result[4:0] back to the destination register.
// - Multi-cycle FSM that processes one instruction at a time, with a valid/ready instruction handshake.
// PARAMETERS
// - DATA_W   5   register/operand width; ALU result width is 2*DATA_W
// - REG_N    8   register count; address width is clog2(REG_N) = 3
// PORTS
// - clk          in   1    rising-edge clock
// - rst          in   1    synchronous, active-high reset
// - instr_valid  in   1    instruction offered
// - instr_ready  out  1    stage can accept; high only in IDLE
// - instr        in   11   [10:9] op, [8:6] rd, [5:3] rs, [2:0] rt
// - host_we      in   1    register-file preload write
// - host_addr    in   3    preload address
// - host_data    in   5    preload data
// - dbg_addr     in   3    debug read address
// - dbg_data     out  5    combinational regfile[dbg_addr]
// - alu_a        out  5    operand A, registered
// - alu_b        out  5    operand B, registered
// - alu_control  out  2    ALU op, registered: 00 AND, 01 XOR, 10 ADD, 11 SUB
// - alu_result   in   10   ALU result, combinational from alu_a/alu_b/alu_control
// - alu_zflag    in   1    ALU zero flag (asserted when a==b)
// - done         out  1    one-cycle pulse in WB
// - done_result  out  10   captured result, held until the next capture
// - done_zflag   out  1    captured zflag, held until the next capture
// - busy         out  1    high whenever state != IDLE
// - ovf_sticky   out  1    see CONFIGURATION
// - ovf_clr      in   1    see CONFIGURATION
// BEHAVIOUR
// - Reset values: state IDLE; all 8 regfile entries 0; alu_a, alu_b, alu_control, done_result, done_zflag,
//   done, ovf_sticky all 0; instr_ready 1.
// - IDLE: instr_ready=1. When instr_valid is high, latch instr and go to READ. host_we writes the regfile,
//   honoured only in IDLE. If host_we and instr_valid are high in the same cycle, both take effect.
// - READ: alu_a<=reg[rs], alu_b<=reg[rt], alu_control<=op; go to EXEC.
// - EXEC: hold the operands; done_result<=alu_result and done_zflag<=alu_zflag; go to WB.
// - WB: reg[rd]<=done_result[4:0] (upper bits discarded); done=1 for exactly this cycle; go to IDLE.
// - Timing: handshake at cycle 0, done at cycle 3, next accept at cycle 4. Peak throughput is 1 instruction per 4 cycles.
// - Hazards: rs or rt equal to rd is legal. Reads always see the value committed by the prior instruction's WB.
// - Ignored inputs: host_we while busy is dropped (no buffering). instr_valid while busy is not accepted.
// - rst in any state: return to IDLE next cycle, clear the regfile, suppress any pending WB and done pulse.
// - No X on outputs after reset. All outputs are registered except dbg_data and instr_ready.
// CONFIGURATION
// - Macro OVF_STICKY_EN.
// - Defined: ovf_sticky is set in WB when done_result[9:5] != 0. ovf_clr clears it.
//   ovf_clr wins over a same-cycle set. rst clears it.
// - Undefined: ovf_sticky is tied to 0 and ovf_clr is ignored. The port list is identical either way.
// STRUCTURE
// - Package alu_pkg:
//   - op localparams OP_AND/OP_XOR/OP_ADD/OP_SUB
//   - state enum IDLE/READ/EXEC/WB
//   - instr field bit positions
//   - DATA_W/REG_N defaults
// - Sub-module alu_regfile: REG_N x DATA_W, two combinational read ports (rs/rt, plus dbg via mux),
//   one sync write port muxed between host (IDLE) and WB; sync reset to 0.
// - Top level holds only the FSM, the instruction latch and the capture registers.
// TESTING (bench pairs the DUT with an ALU model: and/xor/add/sub zero-extended to 10 bits, zflag=(a==b))
// - Preload r1=3, r2=5; ADD rd=3 rs=1 rt=2 -> done at cycle 3; done_result=10'd8; dbg r3=8; done_zflag=0.
// - r1=2, r2=5; SUB rd=4 -> done_result=10'h3FD; r4=5'h1D; with OVF_STICKY_EN, ovf_sticky=1; ovf_clr -> 0.
// - r5=r6=9; XOR rd=5 rs=5 rt=6 -> done_zflag=1, r5=0. A following AND rs=5 must read the new r5=0.
// - instr_valid held high for 12 cycles -> exactly 3 accepts (instr_ready high only in cycles 0, 4, 8);
//   host_we during busy leaves the regfile unchanged.
// - rst asserted in EXEC -> next cycle IDLE, no done pulse, all regs 0, instr_ready=1.
// - Without OVF_STICKY_EN, repeat the SUB case -> ovf_sticky stays 0 throughout.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: op codes, FSM states,
// instruction field positions and default sizing.
package alu_pkg;

    localparam int DEF_DATA_W = 5;
    localparam int DEF_REG_N  = 8;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    // Instruction layout: [10:9] op, [8:6] rd, [5:3] rs, [2:0] rt
    localparam int OP_MSB = 10;
    localparam int OP_LSB = 9;
    localparam int RD_MSB = 8;
    localparam int RD_LSB = 6;
    localparam int RS_MSB = 5;
    localparam int RS_LSB = 3;
    localparam int RT_MSB = 2;
    localparam int RT_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU issue stage: REG_N x DATA_W, two operand read
// ports plus a debug read port, one synchronous write port, sync reset to 0.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_N  = DEF_REG_N,
    parameter int AW     = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [AW-1:0]     raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic [AW-1:0]     dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] mem_q [REG_N];

    // Storage: clear every entry on reset, otherwise single-port write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o  = mem_q[raddr_a_i];
    assign rdata_b_o  = mem_q[raddr_b_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: accepts one instruction at a time, reads operands,
// drives the external ALU, captures its result and writes it back.
// Optional feature: define OVF_STICKY_EN to enable the sticky overflow flag.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_N  = DEF_REG_N,
    parameter int AW     = $clog2(REG_N),
    parameter int IW     = 2 + 3 * AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [IW-1:0]       instr,
    input  logic                host_we,
    input  logic [AW-1:0]       host_addr,
    input  logic [DATA_W-1:0]   host_data,
    input  logic [AW-1:0]       dbg_addr,
    output logic [DATA_W-1:0]   dbg_data,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [1:0]          alu_control,
    input  logic [2*DATA_W-1:0] alu_result,
    input  logic                alu_zflag,
    output logic                done,
    output logic [2*DATA_W-1:0] done_result,
    output logic                done_zflag,
    output logic                busy,
    output logic                ovf_sticky,
    input  logic                ovf_clr
);

    state_e              state_q, state_d;
    logic [IW-1:0]       instr_q;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q;
    logic [1:0]          alu_ctrl_q;
    logic [2*DATA_W-1:0] res_q;
    logic                zf_q;
    logic                done_q;
    logic                ovf_q;

    logic [AW-1:0]       rd, rs, rt;
    logic [DATA_W-1:0]   rdata_a, rdata_b;
    logic                rf_we;
    logic [AW-1:0]       rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;

    assign rd = instr_q[RD_MSB:RD_LSB];
    assign rs = instr_q[RS_MSB:RS_LSB];
    assign rt = instr_q[RT_MSB:RT_LSB];

    // Host preload only lands in IDLE; writeback owns the port in WB
    assign rf_we    = (state_q == IDLE && host_we) || (state_q == WB);
    assign rf_waddr = (state_q == WB) ? rd : host_addr;
    assign rf_wdata = (state_q == WB) ? res_q[DATA_W-1:0] : host_data;

    alu_regfile #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N),
        .AW     (AW)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we_i       (rf_we),
        .waddr_i    (rf_waddr),
        .wdata_i    (rf_wdata),
        .raddr_a_i  (rs),
        .rdata_a_o  (rdata_a),
        .raddr_b_i  (rt),
        .rdata_b_o  (rdata_b),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: fixed IDLE -> READ -> EXEC -> WB -> IDLE sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: instruction latch, operands, result capture, done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= '0;
            res_q      <= '0;
            zf_q       <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            // done is registered, so it is raised on entry to WB
            done_q <= (state_d == WB);
            case (state_q)
                IDLE: if (instr_valid) instr_q <= instr;
                READ: begin
                    alu_a_q    <= rdata_a;
                    alu_b_q    <= rdata_b;
                    alu_ctrl_q <= instr_q[OP_MSB:OP_LSB];
                end
                EXEC: begin
                    res_q <= alu_result;
                    zf_q  <= alu_zflag;
                end
                default: ;
            endcase
`ifdef OVF_STICKY_EN
            if (ovf_clr)
                ovf_q <= 1'b0;
            else if (state_q == WB && res_q[2*DATA_W-1:DATA_W] != '0)
                ovf_q <= 1'b1;
`endif
        end
    end

`ifndef OVF_STICKY_EN
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
`endif

    assign instr_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctrl_q;
    assign done        = done_q;
    assign done_result = res_q;
    assign done_zflag  = zf_q;
    assign ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with an ALU model and a
// reference register-file model. Honours OVF_STICKY_EN like the RTL.
module tb_alu_issue_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [10:0] instr;
    logic       host_we;
    logic [2:0] host_addr;
    logic [4:0] host_data;
    logic [2:0] dbg_addr;
    logic [4:0] dbg_data;
    logic [4:0] alu_a, alu_b;
    logic [1:0] alu_control;
    logic [9:0] alu_result;
    logic       alu_zflag;
    logic       done;
    logic [9:0] done_result;
    logic       done_zflag;
    logic       busy;
    logic       ovf_sticky;
    logic       ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;
    int mdl_rf [8];
    int mdl_ovf;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_data   (host_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zflag   (alu_zflag),
        .done        (done),
        .done_result (done_result),
        .done_zflag  (done_zflag),
        .busy        (busy),
        .ovf_sticky  (ovf_sticky),
        .ovf_clr     (ovf_clr)
    );

    // External ALU: zero-extended 10-bit results, zflag on equal operands
    always_comb begin
        case (alu_control)
            2'b00:   alu_result = {5'b0, alu_a & alu_b};
            2'b01:   alu_result = {5'b0, alu_a ^ alu_b};
            2'b10:   alu_result = {5'b0, alu_a} + {5'b0, alu_b};
            default: alu_result = {5'b0, alu_a} - {5'b0, alu_b};
        endcase
        alu_zflag = (alu_a == alu_b);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            0:       return a & b;
            1:       return a ^ b;
            2:       return a + b;
            default: return (a - b + 1024) % 1024;
        endcase
    endfunction

    task automatic preload(input int addr, input int data);
        host_we   = 1'b1;
        host_addr = addr[2:0];
        host_data = data[4:0];
        tick();
        host_we   = 1'b0;
        mdl_rf[addr] = data % 32;
    endtask

    task automatic run_instr(input int op, input int rd, input int rs, input int rt);
        int exp_res, exp_z, waited;
        waited = 0;
        while (!instr_ready && waited < 20) begin
            tick();
            waited++;
        end
        check_eq("ready_before_issue", {31'b0, instr_ready}, 1);
        exp_res = ref_alu(op, mdl_rf[rs], mdl_rf[rt]);
        exp_z   = (mdl_rf[rs] == mdl_rf[rt]) ? 1 : 0;
        instr_valid = 1'b1;
        instr       = {op[1:0], rd[2:0], rs[2:0], rt[2:0]};
        tick();
        instr_valid = 1'b0;
        check_eq("busy_c1", {31'b0, busy}, 1);
        check_eq("done_c1", {31'b0, done}, 0);
        tick();
        check_eq("done_c2", {31'b0, done}, 0);
        tick();
        check_eq("done_c3", {31'b0, done}, 1);
        check_eq("done_result", {22'b0, done_result}, exp_res);
        check_eq("done_zflag", {31'b0, done_zflag}, exp_z);
        tick();
        check_eq("done_c4", {31'b0, done}, 0);
        check_eq("ready_c4", {31'b0, instr_ready}, 1);
        mdl_rf[rd] = exp_res % 32;
`ifdef OVF_STICKY_EN
        if (exp_res >= 32) mdl_ovf = 1;
`endif
        dbg_addr = rd[2:0];
        #1;
        check_eq("wb_value", {27'b0, dbg_data}, mdl_rf[rd]);
        check_eq("ovf_sticky", {31'b0, ovf_sticky}, mdl_ovf);
    endtask

    initial begin
        int mask, accepts;
        rst = 1'b1; instr_valid = 1'b0; instr = '0; host_we = 1'b0;
        host_addr = '0; host_data = '0; dbg_addr = '0; ovf_clr = 1'b0;
        mdl_ovf = 0;
        for (int i = 0; i < 8; i++) mdl_rf[i] = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_ready", {31'b0, instr_ready}, 1);
        check_eq("rst_busy", {31'b0, busy}, 0);
        check_eq("rst_done", {31'b0, done}, 0);
        check_eq("rst_alu_a", {27'b0, alu_a}, 0);
        check_eq("rst_alu_b", {27'b0, alu_b}, 0);
        check_eq("rst_alu_ctl", {30'b0, alu_control}, 0);
        check_eq("rst_done_result", {22'b0, done_result}, 0);
        check_eq("rst_done_zflag", {31'b0, done_zflag}, 0);
        check_eq("rst_ovf", {31'b0, ovf_sticky}, 0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = i[2:0];
            #1;
            check_eq("rst_rf", {27'b0, dbg_data}, 0);
        end

        // ADD r3 = r1 + r2
        preload(1, 3); preload(2, 5);
        run_instr(2, 3, 1, 2);
        check_eq("add_r3_is_8", {27'b0, dbg_data}, 8);

        // SUB r4 = r1 - r2 wraps to 0x3FD; low five bits 0x1D
        preload(1, 2);
        run_instr(3, 4, 1, 2);
        check_eq("sub_r4_is_1d", {27'b0, dbg_data}, 32'h1D);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        mdl_ovf = 0;
        check_eq("ovf_after_clr", {31'b0, ovf_sticky}, 0);

        // XOR with equal operands, then a dependent AND reads the new r5
        preload(5, 9); preload(6, 9);
        run_instr(1, 5, 5, 6);
        check_eq("xor_r5_is_0", {27'b0, dbg_data}, 0);
        preload(2, 31);
        run_instr(0, 7, 5, 2);

        // Back-to-back offers: one accept per four cycles, busy host writes dropped
        preload(0, 1); preload(7, 2);
        instr_valid = 1'b1;
        instr = {2'b10, 3'd7, 3'd7, 3'd0};
        mask = 0; accepts = 0;
        for (int c = 0; c < 12; c++) begin
            host_we   = !instr_ready;
            host_addr = 3'd7;
            host_data = 5'd31;
            if (instr_ready) begin
                mask = mask | (1 << c);
                accepts++;
            end
            tick();
        end
        instr_valid = 1'b0;
        host_we = 1'b0;
        for (int k = 0; k < 3; k++) mdl_rf[7] = (mdl_rf[7] + mdl_rf[0]) % 32;
        check_eq("accept_count", accepts, 3);
        check_eq("accept_cycles", mask, 32'h111);
        dbg_addr = 3'd7;
        #1;
        check_eq("throughput_r7", {27'b0, dbg_data}, mdl_rf[7]);

        // Reset while in EXEC: no writeback, no done, everything cleared
        instr_valid = 1'b1;
        instr = {2'b10, 3'd6, 3'd7, 3'd7};
        tick();
        instr_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_eq("rstx_ready", {31'b0, instr_ready}, 1);
        check_eq("rstx_busy", {31'b0, busy}, 0);
        check_eq("rstx_done", {31'b0, done}, 0);
        rst = 1'b0;
        tick();
        check_eq("rstx_done_next", {31'b0, done}, 0);
        check_eq("rstx_result", {22'b0, done_result}, 0);
        for (int i = 0; i < 8; i++) begin
            mdl_rf[i] = 0;
            dbg_addr = i[2:0];
            #1;
            check_eq("rstx_rf", {27'b0, dbg_data}, 0);
        end
        mdl_ovf = 0;

        // Randomized instruction stream against the reference model
        for (int i = 0; i < 8; i++) preload(i, int'($urandom_range(31)));
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(3) == 0)
                preload(int'($urandom_range(7)), int'($urandom_range(31)));
            run_instr(int'($urandom_range(3)), int'($urandom_range(7)),
                      int'($urandom_range(7)), int'($urandom_range(7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
